ecg_moving_avg_axis: RTL

//  Boxcar moving-average filter directly downstream of the MCP3202 SPI ADC master in the ECG chain.

---
 rtl/ecg_pkg.sv | 17 +
 rtl/ecg_moving_avg_axis_if.sv | 13 +
 rtl/ecg_ring_ram.sv | 28 ++
 rtl/ecg_moving_avg_axis.sv | 110 +++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG moving-average stage: sample width, beat type, FSM encodings.
package ecg_pkg;
  localparam int ECG_DATA_W = 16;

  typedef struct packed {
    logic [ECG_DATA_W-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
  } ecg_axis_beat_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_UPD  = 2'd2,
    S_OUT  = 2'd3
  } ecg_state_e;
endpackage

// File: rtl/ecg_moving_avg_axis_if.sv
// AXI4-Stream data/valid/ready bundle used for both the sample input and the mean output.
interface ecg_moving_avg_axis_if
  import ecg_pkg::*;
#(
  parameter int DATA_W = ECG_DATA_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ecg_ring_ram.sv
// Sample history ring: one write port, one registered read port, no reset so it maps to LUTRAM/BRAM.
module ecg_ring_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rd_d, rd_q;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= rd_d;
  end

  assign rdata = rd_q;
endmodule

// File: rtl/ecg_moving_avg_axis.sv
// Boxcar moving average over the last 2**LOG2_TAPS ADC samples, one result per accepted sample.
module ecg_moving_avg_axis
  import ecg_pkg::*;
#(
  parameter int DATA_W      = ECG_DATA_W,
  parameter int LOG2_TAPS   = 3,
  parameter bit EDGE_ACCEPT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ecg_moving_avg_axis_if.slave  s_axis,
  ecg_moving_avg_axis_if.master m_axis,
  output logic                  primed
);
  localparam int SUM_W = DATA_W + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] TAPS_CNT = (LOG2_TAPS+1)'(1 << LOG2_TAPS);

  ecg_state_e              state_d, state_q;
  logic [DATA_W-1:0]       x_d, x_q;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic [LOG2_TAPS-1:0]    wr_ptr_d, wr_ptr_q;
  logic [LOG2_TAPS:0]      fill_cnt_d, fill_cnt_q;
  logic                    armed_d, armed_q;
  logic                    primed_d, primed_q;
  logic [DATA_W-1:0]       tdata_d, tdata_q;

  logic                    accept;
  logic [DATA_W-1:0]       x_old, x_old_eff;
  logic signed [SUM_W-1:0] x_ext, old_ext, sum_step;

  ecg_ring_ram #(.DATA_W(DATA_W), .AW(LOG2_TAPS)) u_ram (
    .clk   (clk),
    .we    (state_q == S_UPD),
    .waddr (wr_ptr_q),
    .wdata (x_q),
    .re    (state_q == S_READ),
    .raddr (wr_ptr_q),
    .rdata (x_old)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    armed_d    = armed_q;
    tdata_d    = tdata_q;
    accept     = 1'b0;

    // Until the window is full the slot being replaced holds no real sample.
    x_old_eff = (fill_cnt_q < TAPS_CNT) ? '0 : x_old;
    x_ext     = {{LOG2_TAPS{x_q[DATA_W-1]}}, x_q};
    old_ext   = {{LOG2_TAPS{x_old_eff[DATA_W-1]}}, x_old_eff};
    sum_step  = sum_q + x_ext - old_ext;

    case (state_q)
      S_IDLE: begin
        if (s_axis.tvalid && (armed_q || !EDGE_ACCEPT)) begin
          accept  = 1'b1;
          x_d     = s_axis.tdata;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_UPD;
      S_UPD: begin
        sum_d    = sum_step;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_cnt_q < TAPS_CNT) fill_cnt_d = fill_cnt_q + 1'b1;
        tdata_d  = DATA_W'(sum_step >>> LOG2_TAPS);
        state_d  = S_OUT;
      end
      S_OUT: if (m_axis.tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Re-arm whenever valid drops; an accept in the same cycle takes priority.
    if (!s_axis.tvalid) armed_d = 1'b1;
    if (accept)         armed_d = 1'b0;

    primed_d = (fill_cnt_q == TAPS_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      armed_q    <= 1'b1;
      primed_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      armed_q    <= armed_d;
      primed_q   <= primed_d;
      tdata_q    <= tdata_d;
    end
  end

  assign s_axis.tready = (state_q == S_IDLE);
  assign m_axis.tvalid = (state_q == S_OUT);
  assign m_axis.tdata  = tdata_q;
  assign primed        = primed_q;
endmodule
